// File: rtl/dbg_uart_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : dbg_uart_frame_rx
// Description : UART byte-stream command front-end for the debug module.
//               Collects 9-byte frames (cmd, addr[4] LE, data[4] LE), issues
//               them as a parallel request on the debug command port, waits
//               for completion or timeout, then returns a status byte and,
//               for successful reads, 4 result bytes (LE) to the UART TX.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   RX_TIMEOUT   idle cycles between frame bytes before a partial frame is
//                discarded
//   DBG_TIMEOUT  max cycles a debug request may remain outstanding
// Ports
//   clk          clock
//   rstn_i       asynchronous active-low reset
//   rx_data_i    received byte            rx_valid_i   one-cycle byte strobe
//   tx_data_o    byte to transmit         tx_valid_o   held until accepted
//   tx_ready_i   transmitter accepts byte when high with tx_valid_o
//   dbg_cmd_o    command (8'h00 when not issuing)
//   dbg_addr_o   request address          dbg_data_o   request write data
//   dbg_data_i   result data              dbg_ready_i  request complete
//   rx_drop_o    pulse: received byte discarded
//   frame_err_o  pulse: partial frame discarded on inter-byte timeout
// ============================================================================
module dbg_uart_frame_rx #(
  parameter int RX_TIMEOUT  = 100000,
  parameter int DBG_TIMEOUT = 65536
) (
  input  logic        clk,
  input  logic        rstn_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [7:0]  dbg_cmd_o,
  output logic [31:0] dbg_addr_o,
  output logic [31:0] dbg_data_o,
  input  logic [31:0] dbg_data_i,
  input  logic        dbg_ready_i,
  output logic        rx_drop_o,
  output logic        frame_err_o
);

  localparam int               RXT_W       = $clog2(RX_TIMEOUT + 1);
  localparam logic [RXT_W-1:0] RX_TMO_MAX  = RXT_W'(RX_TIMEOUT);
  localparam logic [31:0]      DBG_TMO_MAX = 32'(DBG_TIMEOUT);
  localparam logic [7:0]       ST_OK       = 8'hA5;
  localparam logic [7:0]       ST_BAD_CMD  = 8'hE0;
  localparam logic [7:0]       ST_DBG_TMO  = 8'hE1;

  typedef enum logic [2:0] {
    RX_CMD    = 3'd0,
    RX_ADDR   = 3'd1,
    RX_DATA   = 3'd2,
    CHECK     = 3'd3,
    ISSUE     = 3'd4,
    RESP_STAT = 3'd5,
    RESP_DATA = 3'd6
  } state_t;

  state_t state, state_next;

  logic [7:0]       cmd;
  logic [31:0]      addr;
  logic [31:0]      data;
  logic [31:0]      result;
  logic [7:0]       status;
  logic [1:0]       byte_cnt;
  logic [RXT_W-1:0] rx_timer;
  logic [31:0]      issue_cnt;

  logic rx_phase;
  logic busy_phase;
  logic rx_tmo_hit;
  logic rx_take;
  logic tx_fire;
  logic cmd_valid;
  logic cmd_is_read;
  logic dbg_done;
  logic dbg_tmo;

  function automatic logic [31:0] put_byte(input logic [31:0] w,
                                           input logic [1:0]  idx,
                                           input logic [7:0]  b);
    logic [31:0] r;
    r = w;
    case (idx)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] w,
                                          input logic [1:0]  idx);
    logic [7:0] r;
    case (idx)
      2'd0:    r = w[7:0];
      2'd1:    r = w[15:8];
      2'd2:    r = w[23:16];
      default: r = w[31:24];
    endcase
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= RX_CMD;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and control strobes
  // --------------------------------------------------------------------------
  always_comb begin
    state_next  = state;
    rx_phase    = (state == RX_ADDR) || (state == RX_DATA);
    busy_phase  = (state == CHECK) || (state == ISSUE) ||
                  (state == RESP_STAT) || (state == RESP_DATA);
    // A byte arriving in the same cycle the timeout expires loses.
    rx_tmo_hit  = rx_phase && (rx_timer == RX_TMO_MAX);
    rx_take     = rx_valid_i && !rx_tmo_hit;
    tx_fire     = tx_valid_o && tx_ready_i;
    cmd_valid   = (cmd[7:3] == 5'd0) || (cmd == 8'h10) || (cmd == 8'h20);
    cmd_is_read = (cmd == 8'h01) || (cmd == 8'h10);
    // issue_cnt is 0 in the first ISSUE cycle, where dbg_ready_i still
    // reflects the previous request.
    dbg_done    = (state == ISSUE) && (issue_cnt != 32'd0) && dbg_ready_i;
    dbg_tmo     = (state == ISSUE) && !dbg_done && (issue_cnt == DBG_TMO_MAX);

    case (state)
      RX_CMD: begin
        if (rx_valid_i) state_next = RX_ADDR;
      end
      RX_ADDR: begin
        if (rx_tmo_hit)                          state_next = RX_CMD;
        else if (rx_take && (byte_cnt == 2'd3))  state_next = RX_DATA;
      end
      RX_DATA: begin
        if (rx_tmo_hit)                          state_next = RX_CMD;
        else if (rx_take && (byte_cnt == 2'd3))  state_next = CHECK;
      end
      CHECK: begin
        state_next = cmd_valid ? ISSUE : RESP_STAT;
      end
      ISSUE: begin
        if (dbg_done || dbg_tmo) state_next = RESP_STAT;
      end
      RESP_STAT: begin
        if (tx_fire) begin
          state_next = (cmd_is_read && (status == ST_OK)) ? RESP_DATA : RX_CMD;
        end
      end
      RESP_DATA: begin
        if (tx_fire && (byte_cnt == 2'd3)) state_next = RX_CMD;
      end
      default: state_next = RX_CMD;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      cmd         <= 8'h00;
      addr        <= 32'd0;
      data        <= 32'd0;
      result      <= 32'd0;
      status      <= 8'h00;
      byte_cnt    <= 2'd0;
      rx_timer    <= '0;
      issue_cnt   <= 32'd0;
      tx_data_o   <= 8'h00;
      tx_valid_o  <= 1'b0;
      dbg_cmd_o   <= 8'h00;
      dbg_addr_o  <= 32'd0;
      dbg_data_o  <= 32'd0;
      rx_drop_o   <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= rx_tmo_hit;
      rx_drop_o   <= rx_valid_i && (busy_phase || rx_tmo_hit);
      // Registered so the command appears exactly in the ISSUE cycles.
      dbg_cmd_o   <= (state_next == ISSUE) ? cmd : 8'h00;

      // Byte index is shared by frame collection and read-data return; it
      // restarts on every state change.
      if (state_next != state) begin
        byte_cnt <= 2'd0;
      end else if ((rx_phase && rx_take) || ((state == RESP_DATA) && tx_fire)) begin
        byte_cnt <= byte_cnt + 2'd1;
      end

      // Inter-byte timer: cleared by each accepted byte, saturating.
      if (rx_phase && !rx_tmo_hit) begin
        if (rx_valid_i) begin
          rx_timer <= '0;
        end else if (rx_timer != RX_TMO_MAX) begin
          rx_timer <= rx_timer + RXT_W'(1);
        end
      end else begin
        rx_timer <= '0;
      end

      case (state)
        RX_CMD: begin
          if (rx_valid_i) cmd <= rx_data_i;
        end
        RX_ADDR: begin
          if (rx_take) addr <= put_byte(addr, byte_cnt, rx_data_i);
        end
        RX_DATA: begin
          if (rx_take) data <= put_byte(data, byte_cnt, rx_data_i);
        end
        CHECK: begin
          result    <= 32'd0;
          issue_cnt <= 32'd0;
          if (cmd_valid) begin
            dbg_addr_o <= addr;
            dbg_data_o <= data;
          end else begin
            status     <= ST_BAD_CMD;
            tx_data_o  <= ST_BAD_CMD;
            tx_valid_o <= 1'b1;
          end
        end
        ISSUE: begin
          if (dbg_done) begin
            result     <= dbg_data_i;
            status     <= ST_OK;
            tx_data_o  <= ST_OK;
            tx_valid_o <= 1'b1;
          end else if (dbg_tmo) begin
            status     <= ST_DBG_TMO;
            tx_data_o  <= ST_DBG_TMO;
            tx_valid_o <= 1'b1;
          end else if (issue_cnt != 32'hFFFF_FFFF) begin
            issue_cnt <= issue_cnt + 32'd1;
          end
        end
        RESP_STAT: begin
          if (tx_fire) begin
            if (state_next == RESP_DATA) tx_data_o <= result[7:0];
            else                         tx_valid_o <= 1'b0;
          end
        end
        RESP_DATA: begin
          if (tx_fire) begin
            if (byte_cnt == 2'd3) tx_valid_o <= 1'b0;
            else                  tx_data_o  <= get_byte(result, byte_cnt + 2'd1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/dbg_uart_frame_rx.md
# dbg_uart_frame_rx

Byte-stream command front-end for the debug module. Collects fixed 9-byte command frames from a UART receiver and presents them as a parallel cmd/addr/data request to the debug module. Waits for the request to complete and returns a status byte, plus read data where the command produces it, to a UART transmitter. Sits between the UART RX/TX byte interfaces and the debug module's command port.

## Interface
- RX_TIMEOUT, default 100000: idle clk cycles between frame bytes before a partial frame is discarded.
- DBG_TIMEOUT, default 65536: max clk cycles a debug request may stay outstanding.
- clk  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- rx_data_i  in  8  received byte.
- rx_valid_i  in  1  one-cycle strobe, rx_data_i valid.
- tx_data_o  out  8  byte to transmit.
- tx_valid_o  out  1  tx_data_o valid; held until accepted.
- tx_ready_i  in  1  transmitter accepts byte when high with tx_valid_o.
- dbg_cmd_o  out  8  command to debug module; 8'h00 when idle.
- dbg_addr_o  out  32  address to debug module.
- dbg_data_o  out  32  write data to debug module.
- dbg_data_i  in  32  result data from debug module.
- dbg_ready_i  in  1  debug module ready (registered on its side).
- rx_drop_o  out  1  one-cycle pulse when a received byte is discarded.
- frame_err_o  out  1  one-cycle pulse on RX timeout discard.

## Operation
- Frame: byte0 = cmd; bytes1-4 = addr, little-endian; bytes5-8 = data, little-endian. All 9 bytes are always sent.
- Valid commands: 8'h00-8'h07, 8'h10, 8'h20. Read-type commands: 8'h01, 8'h10.
- States: RX_CMD, RX_ADDR, RX_DATA, CHECK, ISSUE, RESP_STAT, RESP_DATA.
- RX_CMD: on rx_valid_i, latch cmd and go to RX_ADDR with byte counter = 0.
- RX_ADDR and RX_DATA: each rx_valid_i shifts into byte position [counter]. After 4 bytes, advance to the next state. The last data byte moves the FSM to CHECK.
- Inter-byte timer: reset on every accepted byte and counts in RX_ADDR/RX_DATA. When it reaches RX_TIMEOUT, discard the frame, pulse frame_err_o, and return to RX_CMD.
- CHECK (1 cycle): if the command is valid, go to ISSUE. Otherwise set status 8'hE0 and go to RESP_STAT without issuing.
- ISSUE: drive dbg_cmd_o/dbg_addr_o/dbg_data_o from the latched frame, stable for the whole state.
  - dbg_ready_i is ignored in the first ISSUE cycle, because it is stale.
  - On the first cycle ≥1 with dbg_ready_i = 1: capture dbg_data_i into the result register, set status 8'hA5, and go to RESP_STAT.
  - If the outstanding counter reaches DBG_TIMEOUT: set status 8'hE1, leave the result at 0, and go to RESP_STAT.
- dbg_cmd_o is 8'h00 in every state except ISSUE. dbg_addr_o and dbg_data_o hold their last latched values.
- RESP_STAT: present the status byte. On transfer:
  - for a read-type command with status A5, go to RESP_DATA;
  - otherwise go to RX_CMD.
- RESP_DATA: send the result as 4 bytes, little-endian, then go to RX_CMD.
- A byte with rx_valid_i in CHECK, ISSUE, RESP_STAT or RESP_DATA is dropped and pulses rx_drop_o. There is no buffering.

## Timing
- Reset values:
  - state RX_CMD
  - dbg_cmd_o, dbg_addr_o, dbg_data_o = 0
  - tx_valid_o = 0, tx_data_o = 0
  - rx_drop_o = 0, frame_err_o = 0
  - all counters and result/status registers = 0
- All outputs are registered.
- ISSUE entry is the cycle after CHECK. Minimum ISSUE length is 2 cycles.
- Debug side with zero internal latency (dbg_ready_i stays 1): last rx byte → dbg_cmd_o valid 2 cycles later → tx_valid_o for status 2 cycles after ISSUE entry.
- TX handshake:
  - tx_valid_o and tx_data_o change only after a cycle with tx_valid_o & tx_ready_i.
  - The next byte is presented in the cycle immediately following a transfer.
  - tx_ready_i held high gives one byte per cycle.
- The debug-outstanding counter is 32 bits wide and does not wrap.
- The RX timeout counter is sized by $clog2(RX_TIMEOUT+1) and saturates.
- rx_valid_i on the same cycle that RX timeout expires: the timeout wins, and the byte is taken as a new cmd byte in RX_CMD on the following cycles only if it is re-sent.
- Reset mid-frame or mid-request: immediately return to reset values. A partially sent response is abandoned.

## Test plan
- Write frame 02, addr 0x00001000, data 0xDEADBEEF, with the debug model asserting ready after 5 cycles. Require:
  - dbg_cmd_o = 02, addr = 0x1000, data = 0xDEADBEEF, stable until ready;
  - a single tx byte A5;
  - dbg_cmd_o back to 00.
- Read frame 01, addr 0x4, with the debug model returning 0x12345678. Require tx bytes A5, 78, 56, 34, 12 in order, with tx_ready_i toggling randomly.
- Reset command 05 with dbg_ready_i constantly 1. Require ISSUE to last exactly 2 cycles and tx A5.
- Unknown cmd 8'h33 frame. Require dbg_cmd_o to stay 00 throughout and tx E0.
- Send 4 bytes, then idle RX_TIMEOUT cycles. Require:
  - a frame_err_o pulse;
  - a following complete 03 frame processed normally (tx A5).
- Debug model never ready. Require:
  - tx E1 after DBG_TIMEOUT cycles;
  - rx bytes injected during ISSUE each pulse rx_drop_o and are ignored.
